// File: rtl/simon_pattern_ctrl_pkg.sv
// Shared types and constants for the Simon pattern controller.
// Symbols are 2-bit indices into the four buttons/LEDs.
package simon_pkg;

  localparam int DEPTH_DEFAULT = 5;
  localparam int SYM_W         = 2;
  localparam int NBTN          = 4;
  localparam int SEL_W         = 3;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    ARMED    = 2'd1,
    HELD     = 2'd2
  } cap_state_t;

  function automatic logic [NBTN-1:0] sym_to_onehot(input logic [SYM_W-1:0] sym);
    logic [NBTN-1:0] r;
    r      = '0;
    r[sym] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/simon_pattern_ctrl_if.sv
// Game-FSM side of the pattern controller, plus the capture FSM state for debug.
// input_done is a one-cycle valid with no ready (the game FSM must always accept it);
// input_correct is meaningful only in the cycle input_done is high and is 0 otherwise.
interface simon_pattern_ctrl_if;
  import simon_pkg::*;

  logic             gen;
  logic             training;
  logic [SEL_W-1:0] training_sel;
  logic             testing;
  logic [SEL_W-1:0] testing_sel;
  logic             input_done;
  logic             input_correct;
  cap_state_t       cap_state;

  modport master (
    output gen, training, training_sel, testing, testing_sel,
    input  input_done, input_correct, cap_state
  );

  modport slave (
    input  gen, training, training_sel, testing, testing_sel,
    output input_done, input_correct, cap_state
  );

endinterface

// File: rtl/simon_pattern_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting toward the MSB.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = {state_q[14:0], state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SEED;
    else          state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/simon_pattern_ctrl.sv
// Simon pattern controller: holds the symbol pattern, blinks it during training,
// and turns synchronized button press/release into the input_done/input_correct pulse.
module simon_pattern_ctrl
  import simon_pkg::*;
#(
  parameter int          DEPTH       = DEPTH_DEFAULT,
  parameter int          SHOW_CYCLES = 3,
  parameter int          GAP_CYCLES  = 1,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NBTN-1:0]      buttons,
  output logic [NBTN-1:0]      leds,
  simon_pattern_ctrl_if.slave  game
);

  localparam int               PERIOD    = SHOW_CYCLES + GAP_CYCLES;
  localparam int               PH_W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [SEL_W-1:0] DEPTH_SEL = SEL_W'(DEPTH);

  logic [15:0]      lfsr;
  logic [SYM_W-1:0] pattern_q [DEPTH];
  logic [SYM_W-1:0] pattern_d [DEPTH];
  logic [NBTN-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NBTN-1:0]  btn_s;
  logic [PH_W-1:0]  phase_q, phase_d, phase_cur;
  logic             train_q, train_d;
  logic [SEL_W-1:0] tsel_q, tsel_d;
  cap_state_t       state_q, state_d;
  logic [NBTN-1:0]  press_q, press_d;
  logic             done_q, done_d;
  logic             correct_q, correct_d;
  logic             restart;
  logic             train_sel_ok, test_sel_ok;
  logic [SYM_W-1:0] train_sym, test_sym;
  logic             press_onehot;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .state   (lfsr)
  );

  assign btn_s = sync2_q;

  always_comb begin
    sync1_d = buttons;
    sync2_d = sync1_q;
    pattern_d = pattern_q;
    if (game.gen) begin
      for (int i = 0; i < DEPTH; i++) pattern_d[i] = lfsr[SYM_W*i +: SYM_W];
    end
  end

  // The blink restarts in the same cycle training rises or the slot changes,
  // so the first visible cycle of a new slot is always an on-cycle.
  always_comb begin
    train_sel_ok = game.training_sel < DEPTH_SEL;
    train_sym    = train_sel_ok ? pattern_q[game.training_sel] : '0;
    restart      = game.training && (!train_q || (game.training_sel != tsel_q));
    phase_cur    = restart ? '0 : phase_q;
    phase_d      = '0;
    if (game.training) begin
      phase_d = (phase_cur == PH_W'(PERIOD - 1)) ? '0 : phase_cur + PH_W'(1);
    end
    train_d = game.training;
    tsel_d  = game.training_sel;

    leds = '0;
    if (game.training) begin
      if (train_sel_ok && (phase_cur < PH_W'(SHOW_CYCLES))) leds = sym_to_onehot(train_sym);
    end else if (game.testing) begin
      leds = btn_s;
    end
  end

  always_comb begin
    test_sel_ok  = game.testing_sel < DEPTH_SEL;
    test_sym     = test_sel_ok ? pattern_q[game.testing_sel] : '0;
    press_onehot = (press_q != '0) && ((press_q & (press_q - NBTN'(1))) == '0);
    state_d      = state_q;
    press_d      = press_q;
    done_d       = 1'b0;
    correct_d    = 1'b0;
    if (!game.testing) begin
      state_d = WAIT_REL;
      press_d = '0;
    end else begin
      unique case (state_q)
        WAIT_REL: if (btn_s == '0) state_d = ARMED;
        ARMED: begin
          if (btn_s != '0) begin
            state_d = HELD;
            press_d = btn_s;
          end
        end
        HELD: begin
          if (btn_s == '0) begin
            state_d   = ARMED;
            done_d    = 1'b1;
            correct_d = press_onehot && test_sel_ok && (press_q == sym_to_onehot(test_sym));
          end else begin
            press_d = press_q | btn_s;
          end
        end
        default: state_d = WAIT_REL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) pattern_q[i] <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      phase_q   <= '0;
      train_q   <= 1'b0;
      tsel_q    <= '0;
      state_q   <= WAIT_REL;
      press_q   <= '0;
      done_q    <= 1'b0;
      correct_q <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      phase_q   <= phase_d;
      train_q   <= train_d;
      tsel_q    <= tsel_d;
      state_q   <= state_d;
      press_q   <= press_d;
      done_q    <= done_d;
      correct_q <= correct_d;
    end
  end

  assign game.input_done    = done_q;
  assign game.input_correct = correct_q;
  assign game.cap_state     = state_q;

endmodule

// File: tb/tb_simon_pattern_ctrl.sv
// Randomized scoreboard bench for simon_pattern_ctrl: a cycle-level reference model
// predicts leds every cycle and queues {cycle, correct} for every expected input_done.
module tb_simon_pattern_ctrl;
  import simon_pkg::*;

  localparam int          DEPTH = 5;
  localparam int          SHOW  = 3;
  localparam int          GAP   = 1;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] buttons = '0;
  logic [3:0] leds;

  simon_pattern_ctrl_if game_if ();

  simon_pattern_ctrl #(
    .DEPTH(DEPTH), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .SEED(SEED)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .buttons (buttons),
    .leds    (leds),
    .game    (game_if.slave)
  );

  always #5 clk = ~clk;

  // ---------------- clock/cycle bookkeeping ----------------
  int cyc      = 0;
  int n_checks = 0;
  int n_err    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- reference model ----------------
  logic [15:0] m_lfsr    = SEED;
  logic [1:0]  m_pat [DEPTH] = '{default: 2'b00};
  logic [3:0]  m_s1      = '0;
  logic [3:0]  m_s2      = '0;
  int          m_age     = 0;
  bit          m_prev_tr = 1'b0;
  logic [2:0]  m_prev_sel = '0;

  logic [32:0] exp_q [$];

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    // taps for exponents 16,14,13,11 live at bits 15,13,12,10
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  function automatic int cur_age();
    if (game_if.training && (!m_prev_tr || game_if.training_sel != m_prev_sel)) return 0;
    return m_age;
  endfunction

  function automatic logic [3:0] exp_leds();
    logic [2:0] s;
    s = game_if.training_sel;
    if (game_if.training) begin
      if (s < 3'(DEPTH) && (cur_age() % (SHOW + GAP)) < SHOW) return 4'(4'b0001 << m_pat[s]);
      return 4'b0000;
    end
    if (game_if.testing) return m_s2;
    return 4'b0000;
  endfunction

  function automatic logic exp_correct(input logic [3:0] pr);
    logic [2:0] s;
    s = game_if.testing_sel;
    if (s >= 3'(DEPTH)) return 1'b0;
    if ($countones(pr) != 1) return 1'b0;
    return pr == 4'(4'b0001 << m_pat[s]);
  endfunction

  initial forever begin
    int a;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_lfsr = SEED;
      for (int i = 0; i < DEPTH; i++) m_pat[i] = 2'b00;
      m_s1 = '0;
      m_s2 = '0;
      m_age = 0;
      m_prev_tr = 1'b0;
      m_prev_sel = '0;
    end else begin
      a = cur_age();
      if (game_if.gen) begin
        for (int i = 0; i < DEPTH; i++) m_pat[i] = 2'((m_lfsr >> (2 * i)) & 16'h3);
      end
      m_lfsr = lfsr_step(m_lfsr);
      m_s2 = m_s1;
      m_s1 = buttons;
      m_age = game_if.training ? a + 1 : 0;
      m_prev_tr = game_if.training;
      m_prev_sel = game_if.training_sel;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial begin
    logic [32:0] item;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("reset_leds", 32'(leds), 32'h0);
        check("reset_done", 32'(game_if.input_done), 32'h0);
        check("reset_correct", 32'(game_if.input_correct), 32'h0);
      end else begin
        check("leds", 32'(leds), 32'(exp_leds()));
        if (game_if.input_done) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_done: input_done=1 expected 0 at cycle %0d", cyc);
          end else begin
            item = exp_q.pop_front();
            check("done_cycle", 32'(cyc), item[32:1]);
            check("input_correct", 32'(game_if.input_correct), 32'(item[0]));
          end
        end else begin
          check("correct_idle", 32'(game_if.input_correct), 32'h0);
        end
        if (exp_q.size() > 0 && int'(exp_q[0][32:1]) < cyc) begin
          item = exp_q.pop_front();
          n_checks++;
          n_err++;
          $display("FAIL missing_done: no input_done, expected at cycle %0d (now %0d)", item[32:1], cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_release(input logic [3:0] b, input int hold, input logic [3:0] extra,
                               input bit chg_sel, input logic [2:0] new_sel);
    logic [3:0] pr;
    pr = b;
    buttons = b;
    step();
    if (chg_sel) game_if.testing_sel = new_sel;
    for (int i = 1; i < hold; i++) begin
      if (i == 1 && extra != '0) begin
        buttons = b | extra;
        pr = b | extra;
      end
      step();
    end
    buttons = '0;
    exp_q.push_back({32'(cyc + 3), exp_correct(pr)});
    repeat (4) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tries;
    logic [2:0] s;
    logic [3:0] b;
    game_if.gen = 1'b0;
    game_if.training = 1'b0;
    game_if.training_sel = '0;
    game_if.testing = 1'b0;
    game_if.testing_sel = '0;

    repeat (3) step();
    reset_n = 1'b1;

    // all-zero pattern blinks symbol 0
    game_if.training = 1'b1;
    repeat (9) step();
    game_if.training = 1'b0;
    repeat ($urandom_range(1, 20)) step();

    game_if.gen = 1'b1;
    step();
    game_if.gen = 1'b0;
    game_if.training = 1'b1;
    for (int k = 0; k <= DEPTH; k++) begin
      game_if.training_sel = 3'(k);
      repeat (6) step();
    end
    for (int k = 0; k < 10; k++) begin
      game_if.training_sel = 3'($urandom_range(0, 7));
      repeat ($urandom_range(1, 6)) step();
    end
    game_if.training = 1'b0;

    // regenerate until slot 2 holds symbol 1
    tries = 0;
    while (m_pat[2] != 2'b01 && tries < 200) begin
      game_if.gen = 1'b1;
      step();
      game_if.gen = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      tries++;
    end

    game_if.testing_sel = 3'd2;
    game_if.testing = 1'b1;
    repeat (3) step();
    press_release(4'b0010, 4, 4'b0000, 1'b0, 3'd0);
    press_release(4'b1000, 4, 4'b0000, 1'b0, 3'd0);
    press_release(4'b0011, 4, 4'b0000, 1'b0, 3'd0);
    press_release(4'b0010, 4, 4'b0001, 1'b0, 3'd0);

    // testing drops while held: no pulse
    buttons = 4'b0010;
    repeat (3) step();
    game_if.testing = 1'b0;
    step();
    buttons = '0;
    repeat (4) step();

    // held while testing rises: no pulse until a fresh press
    buttons = 4'b0010;
    repeat (3) step();
    game_if.testing = 1'b1;
    repeat (4) step();
    buttons = '0;
    repeat (5) step();
    press_release(4'b0010, 3, 4'b0000, 1'b0, 3'd0);

    for (int k = 0; k < 24; k++) begin
      s = 3'($urandom_range(0, 7));
      game_if.testing_sel = s;
      if ($urandom_range(0, 1) == 1 && s < 3'(DEPTH)) b = 4'(4'b0001 << m_pat[s]);
      else b = 4'($urandom_range(1, 15));
      press_release(b, $urandom_range(1, 5),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
                    1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
    end

    // asynchronous reset while a press is held
    game_if.testing_sel = 3'd2;
    buttons = 4'b0010;
    repeat (4) step();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_leds", 32'(leds), 32'h0);
    check("async_reset_done", 32'(game_if.input_done), 32'h0);
    check("async_reset_correct", 32'(game_if.input_correct), 32'h0);
    game_if.testing = 1'b0;
    buttons = '0;
    repeat (2) step();
    reset_n = 1'b1;
    game_if.training = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      game_if.training_sel = 3'(k);
      repeat (4) step();
    end
    game_if.training = 1'b0;
    repeat (10) step();

    check("pending_at_end", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
